ceti_i2c_target: RTL and testbench

//  I2C target (responder) for the CETI tag FPGA; the bus peer of the ceti_i2c initiator.

---
 rtl/ceti_i2c_target_pkg.sv | 22 ++
 rtl/ceti_i2c_cond_det.sv | 44 ++++
 rtl/ceti_i2c_target.sv | 201 ++++++++++++++++++++
 tb/tb_ceti_i2c_target.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ceti_i2c_target_pkg.sv
// Shared definitions for the CETI I2C target: default address, FSM states, ACK/NAK levels.
package ceti_i2c_target_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

    localparam logic ACK = 1'b0;
    localparam logic NAK = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StIgnore
    } state_e;

endpackage

// File: rtl/ceti_i2c_cond_det.sv
// SCL/SDA synchronizer with SCL edge and START/STOP condition detection.
module ceti_i2c_cond_det #(
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic clk,
    input  logic n_reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_LEN-1:0] scl_sync_q;
    logic [SYNC_LEN-1:0] sda_sync_q;
    logic                scl_prev_q;
    logic                sda_prev_q;
    logic                scl;

    // Idle bus level is high, so reset to 1 to avoid spurious edges after reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_LEN-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_LEN-2:0], sda_in};
            scl_prev_q <= scl_sync_q[SYNC_LEN-1];
            sda_prev_q <= sda_sync_q[SYNC_LEN-1];
        end
    end

    assign scl      = scl_sync_q[SYNC_LEN-1];
    assign sda      = sda_sync_q[SYNC_LEN-1];
    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;
    assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/ceti_i2c_target.sv
// I2C target exposing an 8-bit register map through single-cycle write/read strobes.
module ceti_i2c_target
    import ceti_i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    output logic       reg_rd_req,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    ceti_i2c_cond_det #(
        .SYNC_LEN(SYNC_LEN)
    ) u_cond_det (
        .clk      (clk),
        .n_reset  (n_reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_out_q, sda_out_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wr_data_q, reg_wr_data_d;
    logic       reg_wr_en_q, reg_wr_en_d;
    logic       reg_rd_req_q, reg_rd_req_d;
    logic       busy_q, busy_d;
    logic [7:0] byte_in;
    logic [2:0] tx_idx;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            sda_out_q     <= NAK;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_rd_req_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            sda_out_q     <= sda_out_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_rd_req_q  <= reg_rd_req_d;
            busy_q        <= busy_d;
        end
    end

    // bit_cnt 0..7 counts data bits; 8 = ACK slot before its SCL rise, 9 = after it.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        sda_out_d     = sda_out_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_wr_en_d   = 1'b0;
        reg_rd_req_d  = 1'b0;
        busy_d        = busy_q;
        byte_in       = {shift_q[6:0], sda};
        tx_idx        = 3'd7 - bit_cnt_q[2:0];

        if (start) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_out_d = NAK;
            busy_d    = 1'b0;
        end else if (stop) begin
            state_d   = StIdle;
            sda_out_d = NAK;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                StAddr, StReg, StWdata: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            case (state_q)
                                StAddr: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_d = StAddrAck;
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = StIgnore;
                                    end
                                end
                                StReg: begin
                                    reg_addr_d = byte_in;
                                    state_d    = StRegAck;
                                end
                                default: begin
                                    reg_wr_data_d = byte_in;
                                    reg_wr_en_d   = 1'b1;
                                    state_d       = StWdataAck;
                                end
                            endcase
                        end
                    end
                end
                StAddrAck, StRegAck, StWdataAck: begin
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_out_d = ACK;
                    end else if (scl_rise && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd9;
                        // shift_q[0] still holds the R/W bit of the address byte
                        if (state_q == StAddrAck && shift_q[0]) begin
                            reg_rd_req_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        bit_cnt_d = '0;
                        sda_out_d = NAK;
                        case (state_q)
                            StAddrAck: begin
                                if (shift_q[0]) begin
                                    shift_d   = reg_rd_data;
                                    sda_out_d = reg_rd_data[7];
                                    state_d   = StRdata;
                                end else begin
                                    state_d = StReg;
                                end
                            end
                            StRegAck: state_d = StWdata;
                            default: begin
                                reg_addr_d = reg_addr_q + 8'd1;
                                state_d    = StWdata;
                            end
                        endcase
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = StRdataAck;
                        end
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        sda_out_d = shift_q[tx_idx];
                    end
                end
                StRdataAck: begin
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_out_d = NAK;
                    end else if (scl_rise && bit_cnt_q == 4'd8) begin
                        if (sda == ACK) begin
                            reg_addr_d   = reg_addr_q + 8'd1;
                            reg_rd_req_d = 1'b1;
                            bit_cnt_d    = 4'd9;
                        end else begin
                            state_d = StIgnore;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        shift_d   = reg_rd_data;
                        sda_out_d = reg_rd_data[7];
                        bit_cnt_d = '0;
                        state_d   = StRdata;
                    end
                end
                default: begin
                    sda_out_d = NAK;
                end
            endcase
        end
    end

    assign sda_out     = sda_out_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_rd_req  = reg_rd_req_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ceti_i2c_target.sv
// Directed bench for ceti_i2c_target: bit-banged I2C controller plus a small register file model.
module tb_ceti_i2c_target;

    localparam int Q = 50;

    logic       clk;
    logic       n_reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_out;
    logic [7:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_en;
    logic       reg_rd_req;
    logic [7:0] reg_rd_data;
    logic       busy;

    logic [7:0]  mem [256];
    logic [15:0] wr_log [$];
    logic [7:0]  rd_log [$];
    int          low_cnt;
    int          both_cnt;
    int          n_checks;
    int          n_errors;

    assign sda_bus = sda_m & sda_out;

    ceti_i2c_target dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .scl_in      (scl_m),
        .sda_in      (sda_bus),
        .sda_out     (sda_out),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_req  (reg_rd_req),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) reg_rd_data <= 8'h00;
        else if (reg_rd_req) reg_rd_data <= mem[reg_addr];
    end

    initial begin
        low_cnt  = 0;
        both_cnt = 0;
    end

    always @(negedge clk) begin
        if (reg_wr_en) wr_log.push_back({reg_addr, reg_wr_data});
        if (reg_rd_req) rd_log.push_back(reg_addr);
        if (!sda_out) low_cnt++;
        if (reg_wr_en && reg_rd_req) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(2 * Q);
    endtask

    task automatic bit_wr(input logic b);
        sda_m = b; #(Q);
        scl_m = 1'b1; #(2 * Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic bit_rd(output logic b);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        b = sda_bus; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic byte_wr(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_wr(d[i]);
        bit_rd(ack);
    endtask

    task automatic byte_rd(input logic nak, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_rd(b);
            d[i] = b;
        end
        bit_wr(nak);
    endtask

    logic       ack;
    logic [7:0] rd;
    int         wb;
    int         rb;
    int         lb;

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h05] = 8'h5A;
        mem[8'h10] = 8'hC3;
        mem[8'h11] = 8'h3C;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        n_reset = 1'b0;
        #(47);
        check("rst_sda", sda_out, 1'b1);
        check("rst_addr", reg_addr, 8'h00);
        check("rst_wdata", reg_wr_data, 8'h00);
        check("rst_wen", reg_wr_en, 1'b0);
        check("rst_rreq", reg_rd_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        n_reset = 1'b1;
        #(100);

        // 1: single write
        wb = wr_log.size();
        bus_start();
        byte_wr(8'hA0, ack); check("t1_ack_addr", ack, 1'b0);
        check("t1_busy", busy, 1'b1);
        byte_wr(8'h12, ack); check("t1_ack_reg", ack, 1'b0);
        byte_wr(8'h34, ack); check("t1_ack_data", ack, 1'b0);
        bus_stop();
        check("t1_wr_cnt", wr_log.size() - wb, 1);
        check("t1_wr", wr_log[wb], 16'h1234);
        check("t1_busy_end", busy, 1'b0);
        check("t1_ptr", reg_addr, 8'h13);

        // 2: pointer write then repeated-START read, NAK
        rb = rd_log.size();
        bus_start();
        byte_wr(8'hA0, ack); check("t2_ack_addr", ack, 1'b0);
        byte_wr(8'h05, ack); check("t2_ack_reg", ack, 1'b0);
        bus_rstart();
        byte_wr(8'hA1, ack); check("t2_ack_raddr", ack, 1'b0);
        byte_rd(1'b1, rd);
        bus_stop();
        check("t2_data", rd, 8'h5A);
        check("t2_rd_cnt", rd_log.size() - rb, 1);
        check("t2_rd_addr", rd_log[rb], 8'h05);
        check("t2_ptr", reg_addr, 8'h05);

        // 3: write burst wrapping past 0xFF, then 2-byte read burst
        wb = wr_log.size();
        bus_start();
        byte_wr(8'hA0, ack);
        byte_wr(8'hFE, ack);
        byte_wr(8'h11, ack); check("t3_ack0", ack, 1'b0);
        byte_wr(8'h22, ack); check("t3_ack1", ack, 1'b0);
        byte_wr(8'h33, ack); check("t3_ack2", ack, 1'b0);
        bus_stop();
        check("t3_wr_cnt", wr_log.size() - wb, 3);
        check("t3_wr0", wr_log[wb], 16'hFE11);
        check("t3_wr1", wr_log[wb + 1], 16'hFF22);
        check("t3_wr2", wr_log[wb + 2], 16'h0033);
        rb = rd_log.size();
        bus_start();
        byte_wr(8'hA0, ack);
        byte_wr(8'h10, ack);
        bus_rstart();
        byte_wr(8'hA1, ack);
        byte_rd(1'b0, rd); check("t3_rd0", rd, 8'hC3);
        byte_rd(1'b1, rd); check("t3_rd1", rd, 8'h3C);
        bus_stop();
        check("t3_rd_cnt", rd_log.size() - rb, 2);
        check("t3_rd_a0", rd_log[rb], 8'h10);
        check("t3_rd_a1", rd_log[rb + 1], 8'h11);

        // 4: address mismatch and general call are ignored
        wb = wr_log.size();
        rb = rd_log.size();
        lb = low_cnt;
        bus_start();
        byte_wr(8'hA2, ack); check("t4_nak_addr", ack, 1'b1);
        check("t4_busy_mid", busy, 1'b0);
        byte_wr(8'h12, ack); check("t4_nak_reg", ack, 1'b1);
        byte_wr(8'h34, ack);
        bus_stop();
        bus_start();
        byte_wr(8'h00, ack); check("t4_gcall_nak", ack, 1'b1);
        bus_stop();
        check("t4_no_low", low_cnt - lb, 0);
        check("t4_no_wr", wr_log.size() - wb, 0);
        check("t4_no_rd", rd_log.size() - rb, 0);
        check("t4_busy", busy, 1'b0);

        // 5: STOP after a partial data byte, then a normal write
        wb = wr_log.size();
        bus_start();
        byte_wr(8'hA0, ack);
        byte_wr(8'h12, ack);
        bit_wr(1'b1); bit_wr(1'b0); bit_wr(1'b1); bit_wr(1'b0);
        bus_stop();
        check("t5_no_wr", wr_log.size() - wb, 0);
        check("t5_busy", busy, 1'b0);
        bus_start();
        byte_wr(8'hA0, ack); check("t5_ack_addr", ack, 1'b0);
        byte_wr(8'h20, ack);
        byte_wr(8'h77, ack); check("t5_ack_data", ack, 1'b0);
        bus_stop();
        check("t5_wr_cnt", wr_log.size() - wb, 1);
        check("t5_wr", wr_log[wb], 16'h2077);

        // 6: reset while driving a 0 data bit
        bus_start();
        byte_wr(8'hA0, ack);
        byte_wr(8'h05, ack);
        bus_rstart();
        byte_wr(8'hA1, ack);
        check("t6_driving", sda_out, 1'b0);
        #(2);
        n_reset = 1'b0;
        #(1);
        check("t6_sda", sda_out, 1'b1);
        check("t6_addr", reg_addr, 8'h00);
        check("t6_wdata", reg_wr_data, 8'h00);
        check("t6_wen", reg_wr_en, 1'b0);
        check("t6_rreq", reg_rd_req, 1'b0);
        check("t6_busy", busy, 1'b0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        #(50);
        n_reset = 1'b1;
        #(100);

        check("no_overlap", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
